// File: rtl/fpu_fdiv_iter.sv
// fpu_fdiv_iter: single-precision IEEE-754 divider, q = a / b.
// Radix-2 restoring mantissa divider under a small FSM with a fixed
// 29-cycle issue interval; special operands traverse the same path.
// Rounding is truncation; denormal inputs/results are treated as zero.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   do_fdiv  start pulse, sampled only while idle
//   a, b     dividend / divisor, latched on an accepted start
//   q        quotient, held until the next result
//   valid    one-cycle pulse when q is updated
//   busy     high from the cycle after acceptance through the PACK cycle
//   dz       divide-by-zero flag, updated together with q
module fpu_fdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        do_fdiv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic        valid,
    output logic        busy,
    output logic        dz
);

    localparam int unsigned FW    = 23;   // stored fraction width
    localparam int unsigned MW    = 24;   // mantissa incl. hidden bit
    localparam int unsigned QW    = 25;   // quotient bits
    localparam int unsigned EW    = 10;   // signed working exponent
    localparam int unsigned CW    = 5;
    localparam int unsigned LAST  = 24;   // final DIV counter value

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_DIV, S_NORM, S_PACK
    } state_t;

    typedef enum logic [2:0] {
        SP_NONE, SP_NAN, SP_INF, SP_ZERO, SP_DZ
    } spec_t;

    state_t                 state;
    spec_t                  spec;
    spec_t                  spec_c;
    logic [31:0]            a_r;
    logic [31:0]            b_r;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_d;
    logic signed [EW-1:0]   exp_n;
    logic [QW-1:0]          rem;
    logic [MW-1:0]          divisor;
    logic [QW-1:0]          quo;
    logic [FW-1:0]          mant_n;
    logic [CW-1:0]          cnt;

    logic [7:0]             a_exp_c;
    logic [7:0]             b_exp_c;
    logic                   a_nan_c, a_inf_c, a_zero_c;
    logic                   b_nan_c, b_inf_c, b_zero_c;
    logic                   ge_c;
    logic [MW-1:0]          sub_c;

    // Operand classification of the latched inputs.
    assign a_exp_c  = a_r[30:23];
    assign b_exp_c  = b_r[30:23];
    assign a_nan_c  = (&a_exp_c) && (|a_r[FW-1:0]);
    assign a_inf_c  = (&a_exp_c) && !(|a_r[FW-1:0]);
    assign a_zero_c = (a_exp_c == 8'd0);
    assign b_nan_c  = (&b_exp_c) && (|b_r[FW-1:0]);
    assign b_inf_c  = (&b_exp_c) && !(|b_r[FW-1:0]);
    assign b_zero_c = (b_exp_c == 8'd0);

    // Special-case code, highest priority first.
    always_comb begin
        spec_c = SP_NONE;
        if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c))
            spec_c = SP_NAN;
        else if (a_inf_c)
            spec_c = SP_INF;
        else if (b_inf_c)
            spec_c = SP_ZERO;
        else if (b_zero_c)
            spec_c = SP_DZ;
        else if (a_zero_c)
            spec_c = SP_ZERO;
    end

    // One restoring step; rem - divisor always fits in MW bits when non-negative.
    assign ge_c  = (rem >= {1'b0, divisor});
    assign sub_c = rem[MW-1:0] - divisor;

    // Control FSM and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            spec    <= SP_NONE;
            a_r     <= '0;
            b_r     <= '0;
            sign_r  <= 1'b0;
            exp_d   <= '0;
            exp_n   <= '0;
            rem     <= '0;
            divisor <= '0;
            quo     <= '0;
            mant_n  <= '0;
            cnt     <= '0;
            q       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (do_fdiv) begin
                        a_r   <= a;
                        b_r   <= b;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_r  <= a_r[31] ^ b_r[31];
                    rem     <= {1'b0, 1'b1, a_r[FW-1:0]};
                    divisor <= {1'b1, b_r[FW-1:0]};
                    exp_d   <= $signed({2'b00, a_exp_c}) - $signed({2'b00, b_exp_c})
                               + 10'sd127;
                    spec    <= spec_c;
                    quo     <= '0;
                    cnt     <= '0;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    quo <= {quo[QW-2:0], ge_c};
                    rem <= ge_c ? {sub_c, 1'b0} : {rem[MW-1:0], 1'b0};
                    if (cnt == CW'(LAST)) begin
                        state <= S_NORM;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_NORM: begin
                    // Quotient lies in (0.5, 2): bit 24 is the integer bit.
                    if (quo[QW-1]) begin
                        mant_n <= quo[QW-2:1];
                        exp_n  <= exp_d;
                    end else begin
                        mant_n <= quo[FW-1:0];
                        exp_n  <= exp_d - 10'sd1;
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    dz    <= 1'b0;
                    state <= S_IDLE;
                    unique case (spec)
                        SP_NAN:  q <= 32'h7FC0_0000;
                        SP_INF:  q <= {sign_r, 8'hFF, 23'd0};
                        SP_ZERO: q <= {sign_r, 31'd0};
                        SP_DZ: begin
                            q  <= {sign_r, 8'hFF, 23'd0};
                            dz <= 1'b1;
                        end
                        default: begin
                            if (exp_n >= 10'sd255)
                                q <= {sign_r, 8'hFF, 23'd0};
                            else if (exp_n <= 10'sd0)
                                q <= {sign_r, 31'd0};
                            else
                                q <= {sign_r, exp_n[7:0], mant_n};
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpu_fdiv_iter.md
Name: fpu_fdiv_iter

Overview:
- Single-precision IEEE-754 divider, q = a / b. It is the inverse-operation companion to the FPU multiplier.
- It uses the same one-cycle-start-pulse / one-cycle-valid-pulse handshake, so the FPU sequencer can drive both units the same way.
- Sequential design: a radix-2 restoring mantissa divider controlled by a small FSM.
- Fixed latency for every input, including special cases.

Parameters:
- none. Widths and latency are fixed: 32-bit single precision, 25 quotient iterations.

Ports:
- clk      input   1   clock, rising edge
- rst      input   1   asynchronous, active-low reset
- do_fdiv  input   1   start pulse; sampled only while idle
- a        input   32  dividend; latched on an accepted start
- b        input   32  divisor; latched on an accepted start
- q        output  32  quotient; holds its value until the next result
- valid    output  1   one-cycle pulse when q is updated
- busy     output  1   high from the cycle after acceptance up to and including the PACK cycle
- dz       output  1   divide-by-zero flag; updated together with q

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; q=0, valid=0, busy=0, dz=0; all internal registers cleared. Assertion mid-operation aborts the operation; no valid pulse follows.
- Start: do_fdiv=1 while state=IDLE is accepted at that clock edge (edge 0). a and b are latched; state goes to PREP.
  - do_fdiv while busy=1 is ignored, with no queueing.
- FSM: IDLE -> PREP (1 cycle) -> DIV (25 cycles) -> NORM (1) -> PACK (1) -> IDLE.
  - PREP: unpack fields. Sign = a[31]^b[31]. Mantissas get the hidden 1. Exponent diff = ea - eb + 127, computed as 10-bit signed. Special-case code is set here.
  - DIV: a 5-bit counter runs 0..24. Each cycle one quotient bit: remainder - divisor; if non-negative, keep it and shift in 1; else shift in 0; then remainder <<= 1. The 25-bit quotient lies in (0.5, 2).
  - NORM: if quotient bit 24 = 1, mantissa = bits[23:1]. Otherwise mantissa = bits[22:0] and the exponent is decremented by 1.
  - PACK: register q and dz; valid=1 for exactly this one cycle; state goes to IDLE.
- Latency: valid is high during the cycle following edge 28, counting from acceptance edge 0. Identical for special-case operands, which still traverse the FSM.
- Back-to-back: valid and busy=0 fall in the same cycle as the return to IDLE, so do_fdiv asserted in the valid cycle is accepted. Issue interval is 29 cycles.
- Rounding: truncation (round toward zero). No sticky/guard rounding.
- Denormal inputs (exp=0) are treated as signed zero. Denormal results flush to signed zero.
- Final exponent ≥255 -> ±inf (sign | 0x7F800000). Final exponent ≤0 -> ±0.
- Special-case priority, highest first:
  1. Either operand NaN, 0/0, or inf/inf -> 0x7FC00000, dz=0.
  2. a=inf -> ±inf.
  3. b=inf -> ±0.
  4. b=0 (a finite, nonzero) -> ±inf, dz=1.
  5. a=0 -> ±0.
- dz=0 for every case except item 4. dz holds with q until the next PACK.

Test Plan:
- a=0x40C00000, b=0x40000000 (6/2), start at edge 0 -> q=0x40400000, dz=0, valid high only in the cycle after edge 28; busy high edges 1..28.
- a=0x3F800000, b=0x40400000 (1/3) -> q=0x3EAAAAAA (truncated). Also a=0xC0000000, b=0x3F000000 -> q=0xC0800000.
- 1/0 -> 0x7F800000, dz=1; -1/0 -> 0xFF800000, dz=1; 0/0 -> 0x7FC00000, dz=0; 5/inf (0x40A00000/0x7F800000) -> 0x00000000. Each at latency 28.
- Overflow 0x7F000000/0x3E800000 -> 0x7F800000. Underflow 0x00800000/0x40000000 -> 0x00000000. Denormal dividend 0x00000001/0x3F800000 -> 0x00000000.
- Handshake:
  - do_fdiv with new operands at edge 10 of a running op -> ignored; the first result is unchanged and no extra valid pulse appears.
  - do_fdiv held high during the valid cycle -> second op accepted; its valid arrives 28 cycles after that edge.
- Drive rst=0 asynchronously mid-DIV (edge 15) -> q, valid, busy and dz go to 0 immediately; no valid pulse. After release, 6/2 -> 0x40400000 at the normal latency.
